craft_round_ctrl: RTL and testbench
===================================

CRAFT_ROUND_CTRL -- requirements
Module: craft_round_ctrl

Interface
REQ-001 SHALL have parameter NUM_ROUNDS, default 32, number of CRAFT rounds (range 2..255).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port start  input  1  request to encrypt; sampled only in IDLE.
REQ-005 SHALL have port ack  input  1  host has read ciphertext; sampled only in DONE.
REQ-006 SHALL have port busy  output  1  high in every state except IDLE and DONE.
REQ-007 SHALL have port done  output  1  high while in DONE; held until ack.
REQ-008 SHALL have port ce_sr, CS0, CS1  output  1 each  state register enable and input-select.
REQ-009 SHALL have port ce_kr, CK0  output  1 each  key register enable and mode.
REQ-010 SHALL have port CM0, CM1  output  1 each  mix-columns mode.
REQ-011 SHALL have port r  output  8  current round index, 0..NUM_ROUNDS-1.
REQ-012 SHALL have port tk_sel  output  2  tweakey select, equal to r[1:0].

Function
REQ-013 SHALL implement states IDLE, LOAD, KEY, MIX, SUB, PERMUT, DONE, with a 2-bit phase counter cnt and a 2-bit group counter grp.
REQ-014 IDLE: start=1 -> LOAD, with r:=0, cnt:=0 and grp:=0; start=0 -> stay in IDLE.
REQ-015 LOAD lasts 1 cycle -> KEY; KEY lasts 1 cycle -> MIX with cnt:=0.
REQ-016 MIX lasts 4 cycles (cnt 0..3); at cnt=3 -> SUB with cnt:=0.
REQ-017 SUB lasts 4 cycles. At cnt=3 with grp<3 -> MIX, grp:=grp+1. At cnt=3 with grp=3 -> grp:=0, then: r=NUM_ROUNDS-1 -> DONE, otherwise -> PERMUT.
REQ-018 PERMUT lasts 1 cycle -> KEY with r:=r+1; r SHALL never wrap or exceed NUM_ROUNDS-1.
REQ-019 DONE: ack=1 -> IDLE; ack=0 -> stay in DONE, with r held at NUM_ROUNDS-1.
REQ-020 Latency SHALL be exactly 1+(NUM_ROUNDS-1)*34+33 cycles from the first LOAD cycle to the first DONE cycle; this is 1088 cycles for NUM_ROUNDS=32.
REQ-021 Control outputs SHALL be Moore-decoded from the current state, valid in the same cycle:
  IDLE/DONE: ce_sr=0, ce_kr=0, CM=00 (CS*, CK0 held at 0).
  LOAD: ce_sr=1, CS1:CS0=01, ce_kr=0, CM=00.
  KEY: ce_sr=0, ce_kr=1, CK0=1, CM=00.
  MIX: ce_sr=1, CS=00, ce_kr=0, CM1:CM0=11.
  SUB: ce_sr=1, CS=11, ce_kr=1, CK0=0, CM=11.
  PERMUT: ce_sr=1, CS=10, ce_kr=0, CM=00.
REQ-022 start asserted while busy or in DONE SHALL be ignored and SHALL NOT be queued.
REQ-023 If start and ack are both high in DONE, the block SHALL go to IDLE only; a new LOAD requires start high in a later IDLE cycle.
REQ-024 ack outside DONE SHALL be ignored.
REQ-025 Exactly one state SHALL be active per cycle; an unreachable encoding SHALL return to IDLE on the next edge.

Reset
REQ-026 rst_n=0 at a rising edge SHALL force state=IDLE, r=0, cnt=0 and grp=0, which gives busy=0, done=0 and all enables and selects at 0; this applies from any state, including mid-round.
REQ-027 Reset SHALL take priority over start and ack in the same cycle.
REQ-028 While rst_n=0 the block SHALL assert no enable, and its outputs SHALL reach their reset values after the first clock edge.

Structure
REQ-029 A shared package craft_pkg SHALL hold the state enumeration and the constants MIX_CYCLES=4, SUB_CYCLES=4, GROUPS=4, KEY_CYCLES=1, PERMUT_CYCLES=1 and the default NUM_ROUNDS=32.
REQ-030 The state-to-control decode SHALL be one combinational sub-module, craft_ctrl_decode; the counters and next-state logic stay in craft_round_ctrl.

Verification
REQ-031 Reset, then start=1 for 1 cycle -> busy=1 next cycle; first DONE cycle exactly 1088 cycles after LOAD; done=1 and r=31.
REQ-032 Trace of round 0 -> LOAD(1), KEY(1), then 4x{MIX(4), SUB(4)}, then PERMUT(1), with control outputs per REQ-021 every cycle and r=1 on the following KEY.
REQ-033 start held high for the whole run -> exactly one encryption; done held with ack=0 for 50 cycles, then ack=1 -> IDLE, and a new LOAD follows only after a further start.
REQ-034 rst_n=0 during round 17, SUB cnt=2 -> next cycle IDLE, r=0, all enables 0; a new start completes in 1088 cycles.
REQ-035 start=1 and ack=1 together in DONE -> IDLE, no LOAD that cycle; start in the next IDLE cycle -> LOAD.
REQ-036 NUM_ROUNDS=2 -> DONE entered 1+34+33=68 cycles after LOAD, with tk_sel tracking r[1:0].

Source files
------------

// File: rtl/craft_pkg.sv
// Shared types and constants for the CRAFT round controller.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package craft_pkg;

    localparam int MIX_CYCLES         = 4;
    localparam int SUB_CYCLES         = 4;
    localparam int GROUPS             = 4;
    localparam int KEY_CYCLES         = 1;
    localparam int PERMUT_CYCLES      = 1;
    localparam int DEFAULT_NUM_ROUNDS = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        KEY    = 3'd2,
        MIX    = 3'd3,
        SUB    = 3'd4,
        PERMUT = 3'd5,
        DONE   = 3'd6
    } state_t;

    // Datapath control word decoded from the controller state.
    typedef struct packed {
        logic busy;
        logic done;
        logic ce_sr;
        logic cs1;
        logic cs0;
        logic ce_kr;
        logic ck0;
        logic cm1;
        logic cm0;
    } ctrl_t;

endpackage

// File: rtl/craft_round_ctrl_if.sv
// Host/datapath control bundle of the CRAFT round controller.
// Latency: none (wires only).
// Backpressure: start is only taken in IDLE, ack only in DONE.
interface craft_round_ctrl_if;

    logic       start;
    logic       ack;
    logic       busy;
    logic       done;
    logic       ce_sr;
    logic       CS0;
    logic       CS1;
    logic       ce_kr;
    logic       CK0;
    logic       CM0;
    logic       CM1;
    logic [7:0] r;
    logic [1:0] tk_sel;

    // Host side: issues start/ack, observes status and controls.
    modport master (
        output start, ack,
        input  busy, done, ce_sr, CS0, CS1, ce_kr, CK0, CM0, CM1, r, tk_sel
    );

    // Controller side.
    modport slave (
        input  start, ack,
        output busy, done, ce_sr, CS0, CS1, ce_kr, CK0, CM0, CM1, r, tk_sel
    );

endinterface

// File: rtl/craft_ctrl_decode.sv
// Moore decode of controller state into datapath enables and selects.
// Latency: purely combinational, valid in the same cycle as the state.
// Backpressure: none.
module craft_ctrl_decode
    import craft_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);

    // Every field defaults to 0 so unlisted selects stay parked low.
    always_comb begin
        ctrl = '0;
        case (state)
            LOAD: begin
                ctrl.busy  = 1'b1;
                ctrl.ce_sr = 1'b1;
                ctrl.cs0   = 1'b1;
            end
            KEY: begin
                ctrl.busy  = 1'b1;
                ctrl.ce_kr = 1'b1;
                ctrl.ck0   = 1'b1;
            end
            MIX: begin
                ctrl.busy  = 1'b1;
                ctrl.ce_sr = 1'b1;
                ctrl.cm1   = 1'b1;
                ctrl.cm0   = 1'b1;
            end
            SUB: begin
                ctrl.busy  = 1'b1;
                ctrl.ce_sr = 1'b1;
                ctrl.cs1   = 1'b1;
                ctrl.cs0   = 1'b1;
                ctrl.ce_kr = 1'b1;
                ctrl.cm1   = 1'b1;
                ctrl.cm0   = 1'b1;
            end
            PERMUT: begin
                ctrl.busy  = 1'b1;
                ctrl.ce_sr = 1'b1;
                ctrl.cs1   = 1'b1;
            end
            DONE: begin
                ctrl.done  = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/craft_round_ctrl.sv
// CRAFT round sequencer: LOAD, then per round KEY, 4x{MIX,SUB}, PERMUT (last round skips PERMUT).
// Latency: 1+(NUM_ROUNDS-1)*34+33 cycles from LOAD to DONE.
// Backpressure: start ignored unless IDLE; DONE held until ack.
module craft_round_ctrl
    import craft_pkg::*;
#(
    parameter int NUM_ROUNDS = DEFAULT_NUM_ROUNDS
) (
    input  logic              clk,
    input  logic              rst_n,
    craft_round_ctrl_if.slave bus
);

    localparam logic [7:0] LAST_R    = 8'(NUM_ROUNDS - 1);
    localparam logic [1:0] KEY_LAST  = 2'(KEY_CYCLES - 1);
    localparam logic [1:0] MIX_LAST  = 2'(MIX_CYCLES - 1);
    localparam logic [1:0] SUB_LAST  = 2'(SUB_CYCLES - 1);
    localparam logic [1:0] PERM_LAST = 2'(PERMUT_CYCLES - 1);
    localparam logic [1:0] GRP_LAST  = 2'(GROUPS - 1);

    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic [1:0] grp_q, grp_d;
    logic [7:0] r_q, r_d;
    ctrl_t      ctrl;

    // State and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            grp_q   <= '0;
            r_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grp_q   <= grp_d;
            r_q     <= r_d;
        end
    end

    // Next-state and counter update; cnt is always 0 on entry to every phase.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grp_d   = grp_q;
        r_d     = r_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                    grp_d   = '0;
                    r_d     = '0;
                end
            end
            LOAD: begin
                state_d = KEY;
                cnt_d   = '0;
            end
            KEY: begin
                if (cnt_q == KEY_LAST) begin
                    state_d = MIX;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            MIX: begin
                if (cnt_q == MIX_LAST) begin
                    state_d = SUB;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            SUB: begin
                if (cnt_q == SUB_LAST) begin
                    cnt_d = '0;
                    if (grp_q != GRP_LAST) begin
                        state_d = MIX;
                        grp_d   = grp_q + 2'd1;
                    end else begin
                        grp_d   = '0;
                        state_d = (r_q == LAST_R) ? DONE : PERMUT;
                    end
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            PERMUT: begin
                if (cnt_q == PERM_LAST) begin
                    state_d = KEY;
                    cnt_d   = '0;
                    // Saturate so the round index can never pass the last round.
                    r_d     = (r_q == LAST_R) ? r_q : r_q + 8'd1;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            DONE: begin
                if (bus.ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                grp_d   = '0;
                r_d     = '0;
            end
        endcase
    end

    craft_ctrl_decode u_decode (
        .state (state_q),
        .ctrl  (ctrl)
    );

    assign bus.busy   = ctrl.busy;
    assign bus.done   = ctrl.done;
    assign bus.ce_sr  = ctrl.ce_sr;
    assign bus.CS1    = ctrl.cs1;
    assign bus.CS0    = ctrl.cs0;
    assign bus.ce_kr  = ctrl.ce_kr;
    assign bus.CK0    = ctrl.ck0;
    assign bus.CM1    = ctrl.cm1;
    assign bus.CM0    = ctrl.cm0;
    assign bus.r      = r_q;
    assign bus.tk_sel = r_q[1:0];

endmodule

// File: tb/tb_craft_round_ctrl.sv
// Self-checking bench for craft_round_ctrl (NUM_ROUNDS=32 and NUM_ROUNDS=2 instances).
// Latency: checks LOAD-to-DONE cycle counts through a scoreboard queue.
// Backpressure: exercises held start, held DONE, start+ack collisions and mid-run reset.
module tb_craft_round_ctrl;

    // Control vector order: {busy,done,ce_sr,CS1,CS0,ce_kr,CK0,CM1,CM0}
    localparam logic [8:0] IDLE_V   = 9'b000000000;
    localparam logic [8:0] DONE_V   = 9'b010000000;
    localparam logic [8:0] LOAD_V   = 9'b101010000;
    localparam logic [8:0] KEY_V    = 9'b100001100;
    localparam logic [8:0] MIX_V    = 9'b101000011;
    localparam logic [8:0] SUB_V    = 9'b101111011;
    localparam logic [8:0] PERMUT_V = 9'b101100000;

    typedef struct {
        int lat;
        int r;
    } exp_t;

    logic clk;
    logic rst_n;
    logic sel;          // 0: observe 32-round DUT, 1: observe 2-round DUT
    int   n_chk;
    int   n_err;
    int   cyc;
    int   load_cyc;
    int   loads;
    logic prev_done;
    exp_t sb[$];

    craft_round_ctrl_if i32 ();
    craft_round_ctrl_if i2 ();

    craft_round_ctrl dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (i32)
    );

    craft_round_ctrl #(.NUM_ROUNDS(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (i2)
    );

    logic [8:0] v32, v2, cur_vec;
    logic [7:0] cur_r;
    logic [1:0] cur_tk;
    logic       cur_done;

    assign v32 = {i32.busy, i32.done, i32.ce_sr, i32.CS1, i32.CS0,
                  i32.ce_kr, i32.CK0, i32.CM1, i32.CM0};
    assign v2  = {i2.busy, i2.done, i2.ce_sr, i2.CS1, i2.CS0,
                  i2.ce_kr, i2.CK0, i2.CM1, i2.CM0};
    assign cur_vec  = sel ? v2 : v32;
    assign cur_r    = sel ? i2.r : i32.r;
    assign cur_tk   = sel ? i2.tk_sel : i32.tk_sel;
    assign cur_done = sel ? i2.done : i32.done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (cur_done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        if (cur_done !== 1'b1) check({tag, "_timeout"}, 32'(cur_done), 32'd1);
    endtask

    // Monitor: timestamps LOAD cycles and scores each DONE entry against the queue.
    initial begin
        exp_t e;
        cyc       = 0;
        load_cyc  = 0;
        loads     = 0;
        prev_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (cur_vec === LOAD_V) begin
                load_cyc = cyc;
                loads++;
            end
            if (cur_done === 1'b1 && prev_done !== 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("latency", 32'(cyc - load_cyc), 32'(e.lat));
                    check("done_r", 32'(cur_r), 32'(e.r));
                end
            end
            prev_done = cur_done;
        end
    end

    initial begin
        logic [8:0] ev;
        logic [7:0] er;
        int         loads0;
        n_chk     = 0;
        n_err     = 0;
        sel       = 1'b0;
        rst_n     = 1'b0;
        i32.start = 1'b0;
        i32.ack   = 1'b0;
        i2.start  = 1'b0;
        i2.ack    = 1'b0;

        // Reset state, with start asserted to show reset wins
        i32.start = 1'b1;
        tick();
        tick();
        check("rst_vec32", 32'(v32), 32'(IDLE_V));
        check("rst_r32", 32'(i32.r), 32'd0);
        check("rst_vec2", 32'(v2), 32'(IDLE_V));
        i32.start = 1'b0;
        rst_n = 1'b1;
        tick();
        check("idle_vec", 32'(v32), 32'(IDLE_V));

        // Single encryption with a full round-0 control trace
        sb.push_back('{1088, 31});
        i32.start = 1'b1;
        tick();
        i32.start = 1'b0;
        check("load_vec", 32'(cur_vec), 32'(LOAD_V));
        check("load_r", 32'(cur_r), 32'd0);
        for (int i = 1; i <= 35; i++) begin
            tick();
            if (i == 1 || i == 35)     ev = KEY_V;
            else if (i == 34)          ev = PERMUT_V;
            else if (((i - 2) % 8) < 4) ev = MIX_V;
            else                       ev = SUB_V;
            er = (i == 35) ? 8'd1 : 8'd0;
            check($sformatf("trace_vec_%0d", i), 32'(cur_vec), 32'(ev));
            check($sformatf("trace_r_%0d", i), 32'(cur_r), 32'(er));
            check($sformatf("trace_tk_%0d", i), 32'(cur_tk), 32'(er[1:0]));
        end
        wait_done("runA", 1100);
        check("runA_done_vec", 32'(cur_vec), 32'(DONE_V));
        i32.ack = 1'b1;
        tick();
        i32.ack = 1'b0;
        check("runA_ack_idle", 32'(cur_vec), 32'(IDLE_V));

        // start held for the whole run: exactly one encryption, DONE held 50 cycles
        loads0 = loads;
        sb.push_back('{1088, 31});
        i32.start = 1'b1;
        tick();
        check("runB_load", 32'(cur_vec), 32'(LOAD_V));
        wait_done("runB", 1100);
        for (int i = 0; i < 50; i++) tick();
        check("runB_hold_vec", 32'(cur_vec), 32'(DONE_V));
        check("runB_hold_r", 32'(cur_r), 32'd31);
        check("runB_one_load", 32'(loads - loads0), 32'd1);
        i32.start = 1'b0;
        i32.ack   = 1'b1;
        tick();
        i32.ack   = 1'b0;
        check("runB_idle", 32'(cur_vec), 32'(IDLE_V));
        for (int i = 0; i < 3; i++) tick();
        check("runB_stay_idle", 32'(cur_vec), 32'(IDLE_V));
        check("runB_no_load", 32'(loads - loads0), 32'd1);

        // start/ack pulses while busy are ignored; start+ack in DONE -> IDLE only
        sb.push_back('{1088, 31});
        i32.start = 1'b1;
        tick();
        i32.start = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        i32.start = 1'b1;
        i32.ack   = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        i32.start = 1'b0;
        i32.ack   = 1'b0;
        check("runC_busy", 32'(i32.busy), 32'd1);
        wait_done("runC", 1100);
        i32.start = 1'b1;
        i32.ack   = 1'b1;
        tick();
        i32.ack   = 1'b0;
        check("runC_both_idle", 32'(cur_vec), 32'(IDLE_V));
        tick();
        i32.start = 1'b0;
        check("runC_relaunch", 32'(cur_vec), 32'(LOAD_V));

        // Reset in round 17, SUB cnt=2 (586 cycles after LOAD), then a clean run
        for (int i = 0; i < 586; i++) tick();
        check("mid_sub", 32'(cur_vec), 32'(SUB_V));
        check("mid_r", 32'(cur_r), 32'd17);
        rst_n = 1'b0;
        tick();
        check("mid_rst_vec", 32'(cur_vec), 32'(IDLE_V));
        check("mid_rst_r", 32'(cur_r), 32'd0);
        rst_n = 1'b1;
        sb.push_back('{1088, 31});
        i32.start = 1'b1;
        tick();
        i32.start = 1'b0;
        check("runD_load", 32'(cur_vec), 32'(LOAD_V));
        wait_done("runD", 1100);
        i32.ack = 1'b1;
        tick();
        i32.ack = 1'b0;

        // Two-round instance: DONE 68 cycles after LOAD, tk_sel follows r
        sel = 1'b1;
        tick();
        sb.push_back('{68, 1});
        i2.start = 1'b1;
        tick();
        i2.start = 1'b0;
        check("n2_load", 32'(cur_vec), 32'(LOAD_V));
        for (int i = 1; i <= 68; i++) begin
            tick();
            er = (i >= 35) ? 8'd1 : 8'd0;
            check($sformatf("n2_r_%0d", i), 32'(cur_r), 32'(er));
            check($sformatf("n2_tk_%0d", i), 32'(cur_tk), 32'(er[1:0]));
        end
        check("n2_done_vec", 32'(cur_vec), 32'(DONE_V));
        i2.ack = 1'b1;
        tick();
        i2.ack = 1'b0;
        check("n2_idle", 32'(cur_vec), 32'(IDLE_V));
        tick();

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
